uram_sdp_rd_arb: RTL
====================

# uram_sdp_rd_arb

Two-requester read-port arbiter and sequencer for the UltraRAM simple-dual-port block. It shares the single read port between requesters 0 and 1 and issues at most one read per cycle. It tracks each in-flight read through the RAM's fixed pipeline latency and steers the returned word back to its requester with an ID. The write port is passed through from a single owner.

## Interface
- AWIDTH, 12, RAM address width
- DWIDTH, 72, RAM data width
- NBPIPE, 3, RAM data pipeline depth; must match the attached RAM; total read latency L = NBPIPE+2
- clk  in  1  single clock for the block and the attached RAM
- rst  in  1  reset, synchronous and active-high
- r0_req  in  1  requester 0 read request, level; held until granted
- r0_addr  in  AWIDTH  requester 0 read address, stable while r0_req is high
- r0_gnt  out  1  requester 0 granted this cycle, one cycle per read
- r1_req / r1_addr / r1_gnt  same for requester 1
- wr_en  in  1  write enable, passed to the RAM wea
- wr_addr  in  AWIDTH  write address, passed to the RAM addra
- wr_data  in  DWIDTH  write data, passed to the RAM dina
- mem_en  out  1  RAM read enable; high only in grant cycles
- mem_addrb  out  AWIDTH  RAM read address
- mem_rstb  out  1  RAM output reset; equal to rst
- mem_regceb  out  1  RAM output register enable; constant 1
- mem_doutb  in  DWIDTH  RAM read data
- rsp_valid  out  1  response strobe, one cycle per granted read
- rsp_id  out  1  requester that owns the response
- rsp_data  out  DWIDTH  read data; mem_doutb registered or passed through (see Timing)

## Operation
- Grant logic is combinational from r*_req and the priority state:
  - at most one gnt per cycle;
  - mem_en = r0_gnt | r1_gnt;
  - mem_addrb = the granted requester's address, otherwise r0_addr (don't-care).
- Round-robin arbitration:
  - one-bit register `last` holds the most recent winner;
  - if both requesters are asserting, the non-last requester wins;
  - a single requester always wins;
  - `last` updates only on a grant.
  - Reset value of `last` is 1, so requester 0 wins the first contention.
- Request protocol: a request completes in its grant cycle. A requester wanting back-to-back reads keeps req high and changes addr after each gnt.
- Tag pipeline: shift register of L entries, each {valid, id}.
  - Entry 0 loads {mem_en, granted id} every cycle; all entries shift every cycle.
  - Entry L-1 drives rsp_valid and rsp_id.
  - Responses cannot be backpressured. Requesters must accept any rsp_valid.
- Writes pass through combinationally, with no arbitration against reads.
- Read and write to the same address in the same cycle: the response carries the old data (RAM behaviour). No forwarding.
- Reset:
  - clears all tag-pipeline valids and sets `last` = 1;
  - drives mem_rstb, which zeroes the RAM output register.
  - Reads in flight when rst asserts are dropped; no rsp_valid for them after reset.
  - Requests and gnt are suppressed while rst is high: gnt = 0 and mem_en = 0.

## Timing
- Read issued in cycle T (gnt=1, mem_en=1) → rsp_valid=1 with rsp_data in cycle T+L. Default L = 5.
- Sustained throughput is one read per cycle. With both requesting continuously, grants alternate 0,1,0,1.
- rsp_data = mem_doutb, combinational. rsp_data is valid only while rsp_valid is high.
- Output values during and after reset:
  - r0_gnt = 0, r1_gnt = 0, mem_en = 0, rsp_valid = 0, rsp_id = 0;
  - rsp_data = 0 in the cycle after reset, because the RAM output is reset.
- Reset deasserted in cycle R → the first grant is possible in cycle R.

## Configuration
- URAM_SDP_RD_ARB_STRICT_PRIO_EN
  - Defined: requester 0 has strict priority. r1 is granted only when r0_req=0. `last` is still maintained but ignored.
  - Undefined (default): round-robin as described in Operation.

## Test plan
- Reset with no requests → all outputs 0; assert r0_req with r0_addr=0x010 → r0_gnt in the same cycle; rsp_valid with rsp_id=0 five cycles later carrying mem[0x010].
- Preload mem[0x001]=A, mem[0x002]=B; hold r0_req and r1_req for 4 cycles → grants 0,1,0,1; four responses in consecutive cycles starting at cycle 5 with ids 0,1,0,1.
- Same cycle: wr_en to 0x020 with new value N, and r1 reads 0x020 (old value O) → response data O. A read of 0x020 one cycle later returns N.
- Issue 3 reads, then assert rst for 1 cycle two cycles later → no rsp_valid for the dropped reads; rsp_data = 0 after reset.
- Stress: random requests for 10k cycles with a scoreboard model → every grant has exactly one response at +5 with matching id and data; never two gnts in one cycle.
- With URAM_SDP_RD_ARB_STRICT_PRIO_EN defined, hold both requests → r0_gnt every cycle, r1_gnt never; drop r0_req → r1_gnt in the same cycle.

Source files
------------

// File: rtl/uram_sdp_rd_arb.sv
// Read-port arbiter/sequencer for an UltraRAM SDP block: two requesters share the read port, write port passes through.
// Optional build macro URAM_SDP_RD_ARB_STRICT_PRIO_EN selects strict requester-0 priority instead of round-robin.
module uram_sdp_rd_arb #(
    parameter int AWIDTH = 12,
    parameter int DWIDTH = 72,
    parameter int NBPIPE = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic [AWIDTH-1:0] r0_addr,
    output logic              r0_gnt,
    input  logic              r1_req,
    input  logic [AWIDTH-1:0] r1_addr,
    output logic              r1_gnt,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    output logic              mem_wea,
    output logic [AWIDTH-1:0] mem_addra,
    output logic [DWIDTH-1:0] mem_dina,
    output logic              mem_en,
    output logic [AWIDTH-1:0] mem_addrb,
    output logic              mem_rstb,
    output logic              mem_regceb,
    input  logic [DWIDTH-1:0] mem_doutb,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DWIDTH-1:0] rsp_data
);

    localparam int L = NBPIPE + 2;

    logic          r_last;
    logic [L-1:0]  r_vld;
    logic [L-1:0]  r_id;
    logic          w_g0;
    logic          w_g1;

    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (!rst) begin
`ifdef URAM_SDP_RD_ARB_STRICT_PRIO_EN
            if (r0_req)
                w_g0 = 1'b1;
            else if (r1_req)
                w_g1 = 1'b1;
`else
            // Under contention the requester that did not win last time goes next.
            if (r0_req && r1_req) begin
                w_g0 = r_last;
                w_g1 = !r_last;
            end else if (r0_req) begin
                w_g0 = 1'b1;
            end else if (r1_req) begin
                w_g1 = 1'b1;
            end
`endif
        end
    end

    assign r0_gnt     = w_g0;
    assign r1_gnt     = w_g1;
    assign mem_en     = w_g0 | w_g1;
    assign mem_addrb  = w_g1 ? r1_addr : r0_addr;
    assign mem_rstb   = rst;
    assign mem_regceb = 1'b1;

    assign mem_wea    = wr_en;
    assign mem_addra  = wr_addr;
    assign mem_dina   = wr_data;

    always_ff @(posedge clk) begin
        if (rst)
            r_last <= 1'b1;
        else if (w_g0 | w_g1)
            r_last <= w_g1;
    end

    // Tag pipeline: one {valid, id} slot per RAM latency cycle; reset drops in-flight reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld <= {r_vld[L-2:0], mem_en};
            r_id  <= {r_id[L-2:0], w_g1};
        end
    end

    assign rsp_valid = r_vld[L-1];
    assign rsp_id    = r_id[L-1];
    assign rsp_data  = mem_doutb;

endmodule
